// File: rtl/serial_pkg.sv
// Shared serial-link definitions: transmitter FSM states, frame geometry and the
// odd-parity rule used by both the transmitter and any receiver-side checker.
package serial_pkg;

  localparam int unsigned DATA_BITS       = 8;
  localparam int unsigned FRAME_LEN_PAR   = DATA_BITS + 3;
  localparam int unsigned FRAME_LEN_NOPAR = DATA_BITS + 2;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    GAP
  } tx_state_e;

  // Parity bit that makes the count of ones across data+parity odd.
  function automatic logic odd_parity(input logic [DATA_BITS-1:0] data);
    return ~^data;
  endfunction

endpackage

// File: rtl/serial_tx_fifo.sv
// Synchronous byte FIFO; head entry is combinationally visible, writes land one edge later.
// Backpressure: full_o blocks writes even when a pop happens on the same edge.
module serial_tx_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 8
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           push_i,
  input  logic [WIDTH-1:0]               push_dat_i,
  input  logic                           pop_i,
  output logic [WIDTH-1:0]               head_dat_o,
  output logic                           full_o,
  output logic                           empty_o,
  output logic [$clog2(DEPTH+1)-1:0]     count_o
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [CW-1:0]    count_q;
  logic             wr_en;
  logic             rd_en;

  assign full_o     = (count_q == CW'(DEPTH));
  assign empty_o    = (count_q == '0);
  assign wr_en      = push_i && !full_o;
  assign rd_en      = pop_i && !empty_o;
  assign head_dat_o = mem_q[rd_ptr_q];
  assign count_o    = count_q;

  // DEPTH is a power of two, so the pointers wrap naturally.
  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (wr_en) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (rd_en) rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_q + CW'(wr_en) - CW'(rd_en);
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q] <= push_dat_i;
  end

endmodule

// File: rtl/serial_tx.sv
// Byte-to-bitstream serializer: start, 8 data bits LSB first, optional odd parity, stop, optional gap.
// Start bit appears two edges after an idle accept; in_ready drops only when the FIFO is full.
module serial_tx
  import serial_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned PARITY_EN  = 1,
  parameter int unsigned IDLE_BITS  = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  in_byte,
  input  logic        in_valid,
  output logic        in_ready,
  output logic        out,
  output logic        busy,
  output logic [15:0] frame_cnt
);

  localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);

  tx_state_e            state_q, state_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic [2:0]           bit_cnt_q, bit_cnt_d;
  logic [3:0]           gap_cnt_q, gap_cnt_d;
  logic [15:0]          frame_cnt_q, frame_cnt_d;
  logic                 out_q, out_d;
  logic                 launch;

  logic                 fifo_push;
  logic                 fifo_pop;
  logic [7:0]           fifo_head;
  logic                 fifo_full;
  logic                 fifo_empty;
  logic [CW-1:0]        fifo_count;

  assign in_ready  = !fifo_full && rst;
  assign fifo_push = in_valid && in_ready;

  serial_tx_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (8)
  ) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .push_i     (fifo_push),
    .push_dat_i (in_byte),
    .pop_i      (fifo_pop),
    .head_dat_o (fifo_head),
    .full_o     (fifo_full),
    .empty_o    (fifo_empty),
    .count_o    (fifo_count)
  );

  always_comb begin
    state_d     = state_q;
    shift_d     = shift_q;
    data_d      = data_q;
    bit_cnt_d   = bit_cnt_q;
    gap_cnt_d   = gap_cnt_q;
    frame_cnt_d = frame_cnt_q;
    out_d       = 1'b1;
    fifo_pop    = 1'b0;
    launch      = 1'b0;

    case (state_q)
      IDLE:   launch = 1'b1;
      START: begin
        out_d     = 1'b0;
        bit_cnt_d = '0;
        state_d   = DATA;
      end
      DATA: begin
        out_d     = shift_q[0];
        shift_d   = {1'b0, shift_q[DATA_BITS-1:1]};
        bit_cnt_d = bit_cnt_q + 3'd1;
        if (bit_cnt_q == 3'(DATA_BITS - 1)) state_d = (PARITY_EN != 0) ? PARITY : STOP;
      end
      PARITY: begin
        out_d   = odd_parity(data_q);
        state_d = STOP;
      end
      STOP: begin
        frame_cnt_d = frame_cnt_q + 16'd1;
        if (IDLE_BITS != 0) begin
          gap_cnt_d = '0;
          state_d   = GAP;
        end else begin
          launch = 1'b1;
        end
      end
      GAP: begin
        if (gap_cnt_q == 4'(IDLE_BITS - 1)) launch = 1'b1;
        else gap_cnt_d = gap_cnt_q + 4'd1;
      end
      default: state_d = IDLE;
    endcase

    // Shared exit from IDLE/STOP/GAP: start the next frame if one is buffered.
    if (launch) begin
      if (!fifo_empty) begin
        fifo_pop = 1'b1;
        shift_d  = fifo_head;
        data_d   = fifo_head;
        state_d  = START;
      end else begin
        state_d = IDLE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= IDLE;
      shift_q     <= '0;
      data_q      <= '0;
      bit_cnt_q   <= '0;
      gap_cnt_q   <= '0;
      frame_cnt_q <= '0;
      out_q       <= 1'b1;
    end else begin
      state_q     <= state_d;
      shift_q     <= shift_d;
      data_q      <= data_d;
      bit_cnt_q   <= bit_cnt_d;
      gap_cnt_q   <= gap_cnt_d;
      frame_cnt_q <= frame_cnt_d;
      out_q       <= out_d;
    end
  end

  assign out       = out_q;
  assign busy      = (state_q != IDLE) || (fifo_count != '0);
  assign frame_cnt = frame_cnt_q;

endmodule

// File: tb/tb_serial_tx.sv
// Directed bench for serial_tx: default instance (parity, no gap) and a second
// instance with PARITY_EN=0, IDLE_BITS=3, each decoded by a simple line receiver.
module tb_serial_tx;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_a, rst_b;
  logic [7:0]  byte_a, byte_b;
  logic        vld_a, vld_b;
  logic        rdy_a, rdy_b;
  logic        out_a, out_b;
  logic        busy_a, busy_b;
  logic [15:0] cnt_a, cnt_b;

  int checks = 0;
  int errors = 0;

  serial_tx dut_a (
    .clk(clk), .rst(rst_a), .in_byte(byte_a), .in_valid(vld_a), .in_ready(rdy_a),
    .out(out_a), .busy(busy_a), .frame_cnt(cnt_a)
  );

  serial_tx #(.FIFO_DEPTH(4), .PARITY_EN(0), .IDLE_BITS(3)) dut_b (
    .clk(clk), .rst(rst_b), .in_byte(byte_b), .in_valid(vld_b), .in_ready(rdy_b),
    .out(out_b), .busy(busy_b), .frame_cnt(cnt_b)
  );

  // Line receivers: k=0 decodes dut_a (with parity), k=1 decodes dut_b (no parity).
  logic [7:0] rxq_a[$];
  logic [7:0] rxq_b[$];
  int         rx_bad_a = 0;
  int         ph [2];
  int         bc [2];
  logic [7:0] sh [2];
  logic       pb [2];

  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      logic ln, rs, pe;
      ln = (k == 0) ? out_a : out_b;
      rs = (k == 0) ? rst_a : rst_b;
      pe = (k == 0);
      if (!rs) begin
        ph[k] = 0;
      end else begin
        case (ph[k])
          0: if (ln === 1'b0) begin ph[k] = 1; bc[k] = 0; end
          1: begin
            sh[k] = {ln, sh[k][7:1]};
            bc[k]++;
            if (bc[k] == 8) ph[k] = pe ? 2 : 3;
          end
          2: begin pb[k] = ln; ph[k] = 3; end
          default: begin
            if (ln === 1'b1 && (!pe || (^{sh[k], pb[k]}) === 1'b1)) begin
              if (k == 0) rxq_a.push_back(sh[k]);
              else rxq_b.push_back(sh[k]);
            end else if (k == 0) begin
              rx_bad_a++;
            end
            ph[k] = 0;
          end
        endcase
      end
    end
  end

  task automatic test_reset();
    rst_a = 1'b0; rst_b = 1'b0; vld_a = 1'b0; vld_b = 1'b0; byte_a = '0; byte_b = '0;
    repeat (3) @(negedge clk);
    checks++;
    if ({out_a, rdy_a, busy_a, cnt_a} !== {1'b1, 1'b0, 1'b0, 16'h0000}) begin
      errors++;
      $display("FAIL reset_a got out/rdy/busy/cnt=%b/%b/%b/%h want 1/0/0/0000", out_a, rdy_a, busy_a, cnt_a);
    end
    checks++;
    if ({out_b, rdy_b, busy_b, cnt_b} !== {1'b1, 1'b0, 1'b0, 16'h0000}) begin
      errors++;
      $display("FAIL reset_b got out/rdy/busy/cnt=%b/%b/%b/%h want 1/0/0/0000", out_b, rdy_b, busy_b, cnt_b);
    end
    rst_a = 1'b1; rst_b = 1'b1;
    @(negedge clk);
    checks++;
    if ({rdy_a, rdy_b, out_a, out_b} !== 4'b1111) begin
      errors++;
      $display("FAIL reset_release got rdy_a/rdy_b/out_a/out_b=%b%b%b%b want 1111", rdy_a, rdy_b, out_a, out_b);
    end
  endtask

  task automatic test_single();
    logic [10:0] obs;
    @(negedge clk); byte_a = 8'hA5; vld_a = 1'b1;
    @(negedge clk); vld_a = 1'b0;
    checks++;
    if ({out_a, busy_a} !== 2'b11) begin
      errors++;
      $display("FAIL single_accept got out/busy=%b/%b want 1/1", out_a, busy_a);
    end
    @(negedge clk);
    checks++;
    if (out_a !== 1'b1) begin
      errors++;
      $display("FAIL single_no_bypass got out=%b want 1", out_a);
    end
    obs = '0;
    for (int i = 0; i < 11; i++) begin
      @(negedge clk); obs = {obs[9:0], out_a};
    end
    checks++;
    if (obs !== 11'b01010010111) begin
      errors++;
      $display("FAIL single_frame got %b want 01010010111", obs);
    end
    checks++;
    if ({busy_a, cnt_a} !== {1'b0, 16'd1}) begin
      errors++;
      $display("FAIL single_cnt got busy/cnt=%b/%0d want 0/1", busy_a, cnt_a);
    end
    repeat (3) @(negedge clk);
    checks++;
    if (rxq_a.size() != 1 || rxq_a[0] !== 8'hA5) begin
      errors++;
      $display("FAIL single_rx got size=%0d first=%h want 1/a5", rxq_a.size(), rxq_a.size() ? rxq_a[0] : 8'h00);
    end
    rxq_a.delete();
  endtask

  task automatic test_back_to_back();
    logic [32:0] obs;
    logic [7:0]  exp_b [3] = '{8'h00, 8'hFF, 8'h01};
    @(negedge clk); byte_a = 8'h00; vld_a = 1'b1;
    @(negedge clk); byte_a = 8'hFF;
    @(negedge clk); byte_a = 8'h01;
    @(negedge clk); vld_a = 1'b0;
    obs = '0;
    for (int i = 0; i < 33; i++) begin
      if (i > 0) @(negedge clk);
      obs = {obs[31:0], out_a};
    end
    checks++;
    if (obs !== 33'b00000000011_01111111111_01000000001) begin
      errors++;
      $display("FAIL b2b_stream got %b want 000000000110111111111101000000001", obs);
    end
    repeat (3) @(negedge clk);
    checks++;
    if (rxq_a.size() != 3) begin
      errors++;
      $display("FAIL b2b_rx_count got %0d want 3", rxq_a.size());
    end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (rxq_a.size() <= i || rxq_a[i] !== exp_b[i]) begin
        errors++;
        $display("FAIL b2b_rx_byte%0d got %h want %h", i, rxq_a.size() > i ? rxq_a[i] : 8'hxx, exp_b[i]);
      end
    end
    checks++;
    if ({busy_a, cnt_a} !== {1'b0, 16'd4}) begin
      errors++;
      $display("FAIL b2b_cnt got busy/cnt=%b/%0d want 0/4", busy_a, cnt_a);
    end
    rxq_a.delete();
  endtask

  task automatic test_fill();
    logic [7:0] fb [6] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
    int   idx = 0;
    int   cyc = 0;
    bit   saw_low = 1'b0;
    bit   acc;
    @(negedge clk); byte_a = fb[0]; vld_a = 1'b1;
    while (idx < 6 && cyc < 400) begin
      if (!rdy_a) saw_low = 1'b1;
      acc = rdy_a;
      @(negedge clk); cyc++;
      if (acc) begin
        idx++;
        if (idx < 6) byte_a = fb[idx];
      end
    end
    vld_a = 1'b0;
    checks++;
    if (idx != 6) begin
      errors++;
      $display("FAIL fill_accepts got %0d want 6", idx);
    end
    checks++;
    if (saw_low !== 1'b1) begin
      errors++;
      $display("FAIL fill_backpressure got in_ready_low_seen=%0d want 1", saw_low);
    end
    for (int w = 0; w < 300 && rxq_a.size() < 6; w++) @(negedge clk);
    repeat (2) @(negedge clk);
    checks++;
    if (rxq_a.size() != 6) begin
      errors++;
      $display("FAIL fill_rx_count got %0d want 6", rxq_a.size());
    end
    for (int i = 0; i < 6; i++) begin
      checks++;
      if (rxq_a.size() <= i || rxq_a[i] !== fb[i]) begin
        errors++;
        $display("FAIL fill_rx_byte%0d got %h want %h", i, rxq_a.size() > i ? rxq_a[i] : 8'hxx, fb[i]);
      end
    end
    checks++;
    if ({busy_a, cnt_a} !== {1'b0, 16'd10}) begin
      errors++;
      $display("FAIL fill_cnt got busy/cnt=%b/%0d want 0/10", busy_a, cnt_a);
    end
    rxq_a.delete();
  endtask

  task automatic test_no_parity();
    logic [9:0] obs;
    @(negedge clk); byte_b = 8'h3C; vld_b = 1'b1;
    @(negedge clk); vld_b = 1'b0;
    @(negedge clk);
    checks++;
    if (out_b !== 1'b1) begin
      errors++;
      $display("FAIL nopar_latency got out=%b want 1", out_b);
    end
    obs = '0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk); obs = {obs[8:0], out_b};
    end
    checks++;
    if (obs !== 10'b0001111001) begin
      errors++;
      $display("FAIL nopar_frame got %b want 0001111001", obs);
    end
    checks++;
    if (cnt_b !== 16'd1) begin
      errors++;
      $display("FAIL nopar_cnt got %0d want 1", cnt_b);
    end
    repeat (6) @(negedge clk);
    checks++;
    if (rxq_b.size() != 1 || rxq_b[0] !== 8'h3C) begin
      errors++;
      $display("FAIL nopar_rx got size=%0d first=%h want 1/3c", rxq_b.size(), rxq_b.size() ? rxq_b[0] : 8'h00);
    end
    checks++;
    if (busy_b !== 1'b0) begin
      errors++;
      $display("FAIL nopar_idle got busy=%b want 0", busy_b);
    end
  endtask

  task automatic test_gap();
    logic [22:0] obs;
    @(negedge clk); byte_b = 8'h81; vld_b = 1'b1;
    @(negedge clk); byte_b = 8'h42;
    @(negedge clk); vld_b = 1'b0;
    obs = '0;
    for (int i = 0; i < 23; i++) begin
      @(negedge clk); obs = {obs[21:0], out_b};
    end
    checks++;
    if (obs !== 23'b0100000011_111_0010000101) begin
      errors++;
      $display("FAIL gap_stream got %b want 01000000111110010000101", obs);
    end
    repeat (6) @(negedge clk);
    checks++;
    if (rxq_b.size() != 3 || rxq_b[1] !== 8'h81 || rxq_b[2] !== 8'h42) begin
      errors++;
      $display("FAIL gap_rx got size=%0d want 3 with 81,42 after 3c", rxq_b.size());
    end
    checks++;
    if ({busy_b, cnt_b} !== {1'b0, 16'd3}) begin
      errors++;
      $display("FAIL gap_cnt got busy/cnt=%b/%0d want 0/3", busy_b, cnt_b);
    end
  endtask

  task automatic test_reset_mid();
    logic [10:0] obs;
    @(negedge clk); byte_a = 8'hC3; vld_a = 1'b1;
    @(negedge clk); byte_a = 8'h99;
    @(negedge clk); byte_a = 8'h77;
    @(negedge clk); vld_a = 1'b0;
    // Now showing the start bit of 0xC3; five more cycles reach data bit 4.
    repeat (5) @(negedge clk);
    rst_a = 1'b0;
    @(negedge clk);
    checks++;
    if ({out_a, busy_a, rdy_a, cnt_a} !== {1'b1, 1'b0, 1'b0, 16'h0000}) begin
      errors++;
      $display("FAIL midrst_state got out/busy/rdy/cnt=%b/%b/%b/%h want 1/0/0/0000", out_a, busy_a, rdy_a, cnt_a);
    end
    @(negedge clk); rst_a = 1'b1;
    @(negedge clk);
    checks++;
    if ({rdy_a, busy_a, out_a} !== 3'b101) begin
      errors++;
      $display("FAIL midrst_release got rdy/busy/out=%b/%b/%b want 1/0/1", rdy_a, busy_a, out_a);
    end
    byte_a = 8'h5A; vld_a = 1'b1;
    @(negedge clk); vld_a = 1'b0;
    @(negedge clk);
    obs = '0;
    for (int i = 0; i < 11; i++) begin
      @(negedge clk); obs = {obs[9:0], out_a};
    end
    checks++;
    if (obs !== 11'b00101101011) begin
      errors++;
      $display("FAIL midrst_frame got %b want 00101101011", obs);
    end
    repeat (30) @(negedge clk);
    checks++;
    if (rxq_a.size() != 1 || rxq_a[0] !== 8'h5A) begin
      errors++;
      $display("FAIL midrst_rx got size=%0d first=%h want 1/5a", rxq_a.size(), rxq_a.size() ? rxq_a[0] : 8'h00);
    end
    checks++;
    if ({cnt_a, rx_bad_a} !== {16'd1, 32'd0}) begin
      errors++;
      $display("FAIL midrst_cnt got cnt=%0d bad_frames=%0d want 1/0", cnt_a, rx_bad_a);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_fill();
    test_no_parity();
    test_gap();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog");
  end

endmodule
